// File: rtl/usb_tx_sched.sv
// usb_tx_sched: arbitrates handshake and DATA0 requests in front of the USB TX
// serializer. It issues the start pulse, enforces the inter-packet gap, detects
// a serializer that never starts, and reports the packet outcome.
module usb_tx_sched #(
  parameter int IPG_CYCLES    = 16,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_PKT       = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_req,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic       tx_start,
  output logic [1:0] tx_packet,
  output logic       hs_grant,
  output logic       data_grant,
  output logic       tx_done,
  output logic       timeout_err,
  output logic       size_err,
  output logic       xfer_err,
  output logic       busy,
  output logic [7:0] pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACT,
    S_ACTIVE,
    S_GAP
  } state_t;

  localparam logic [7:0] IPG_LAST   = 8'(IPG_CYCLES - 1);
  localparam logic [7:0] START_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [6:0] MAX_OCC    = 7'(MAX_PKT);

  state_t     state_reg, state_next;
  logic [7:0] timer_reg, timer_next;
  logic       err_reg, err_next;
  logic [1:0] packet_reg, packet_next;
  logic [7:0] count_reg, count_next;
  logic       start_reg, start_next;
  logic       hs_grant_reg, hs_grant_next;
  logic       data_grant_reg, data_grant_next;
  logic       done_reg, done_next;
  logic       timeout_reg, timeout_next;
  logic       size_reg, size_next;
  logic       xfer_reg, xfer_next;
  logic       busy_reg, busy_next;

  // Every output is a flop; the pulses are decided one cycle ahead in the
  // next-state logic so nothing combinational reaches the ports.
  assign tx_start    = start_reg;
  assign tx_packet   = packet_reg;
  assign hs_grant    = hs_grant_reg;
  assign data_grant  = data_grant_reg;
  assign tx_done     = done_reg;
  assign timeout_err = timeout_reg;
  assign size_err    = size_reg;
  assign xfer_err    = xfer_reg;
  assign busy        = busy_reg;
  assign pkt_count   = count_reg;

  // State, timer, error latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      timer_reg      <= 8'd0;
      err_reg        <= 1'b0;
      packet_reg     <= 2'd0;
      count_reg      <= 8'd0;
      start_reg      <= 1'b0;
      hs_grant_reg   <= 1'b0;
      data_grant_reg <= 1'b0;
      done_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      size_reg       <= 1'b0;
      xfer_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      err_reg        <= err_next;
      packet_reg     <= packet_next;
      count_reg      <= count_next;
      start_reg      <= start_next;
      hs_grant_reg   <= hs_grant_next;
      data_grant_reg <= data_grant_next;
      done_reg       <= done_next;
      timeout_reg    <= timeout_next;
      size_reg       <= size_next;
      xfer_reg       <= xfer_next;
      busy_reg       <= busy_next;
    end
  end

  // Next-state decode plus the output values for the following cycle.
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    err_next        = err_reg;
    packet_next     = packet_reg;
    count_next      = count_reg;
    start_next      = 1'b0;
    hs_grant_next   = 1'b0;
    data_grant_next = 1'b0;
    done_next       = 1'b0;
    timeout_next    = 1'b0;
    size_next       = 1'b0;
    xfer_next       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Handshake always wins; a PID of 0 is sent as NAK.
        if (hs_req) begin
          packet_next   = (hs_type == 2'd0) ? 2'd2 : hs_type;
          state_next    = S_START;
          start_next    = 1'b1;
          hs_grant_next = 1'b1;
        end else if (data_req) begin
          if (buffer_occupancy <= MAX_OCC) begin
            packet_next     = 2'd0;
            state_next      = S_START;
            start_next      = 1'b1;
            data_grant_next = 1'b1;
          end else begin
            // Oversize payload: reject, but still honour the gap.
            size_next  = 1'b1;
            timer_next = 8'd0;
            state_next = S_GAP;
          end
        end
      end
      S_START: begin
        timer_next = 8'd0;
        state_next = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        // Serializer errors before it goes active are not attributed to the packet.
        if (tx_transfer_active) begin
          state_next = S_ACTIVE;
        end else if (timer_reg == START_LAST) begin
          timeout_next = 1'b1;
          timer_next   = 8'd0;
          state_next   = S_GAP;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      S_ACTIVE: begin
        if (tx_error) begin
          err_next = 1'b1;
        end
        if (!tx_transfer_active) begin
          timer_next = 8'd0;
          state_next = S_GAP;
          if (err_reg || tx_error) begin
            xfer_next = 1'b1;
          end else begin
            done_next  = 1'b1;
            count_next = count_reg + 8'd1;
          end
        end
      end
      S_GAP: begin
        if (timer_reg == IPG_LAST) begin
          timer_next = 8'd0;
          err_next   = 1'b0;
          state_next = S_IDLE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

endmodule

// File: doc/usb_tx_sched.md
# usb_tx_sched

Transmit scheduler sitting directly in front of the USB TX serializer. It owns the serializer's `tx_start`/`tx_packet` controls and arbitrates between two requesters:
- the protocol handshake path, which asks for ACK/NAK/STALL;
- the data buffer path, which asks for a DATA0 packet.

It enforces an inter-packet gap, detects a serializer that never starts, rejects oversize data packets, and reports completion back to the winning requester.

## Interface
Parameters:
- `IPG_CYCLES`, default 16: idle clocks enforced after each packet or error (2 bit times at 8 clk/bit). Range 1..255.
- `START_TIMEOUT`, default 16: clocks allowed between `tx_start` and `tx_transfer_active` rising. Range 1..255.
- `MAX_PKT`, default 64: largest permitted DATA0 payload, in bytes. Range 0..127.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `hs_req` in 1: handshake request, level. Held until `hs_grant`.
- `hs_type` in 2: requested PID (1=ACK, 2=NAK, 3=STALL). Value 0 is treated as NAK.
- `data_req` in 1: DATA0 request, level. Held until `data_grant` or `size_err`.
- `buffer_occupancy` in 7: payload bytes currently queued.
- `tx_transfer_active` in 1: serializer busy, from the TX block.
- `tx_error` in 1: serializer error, from the TX block.
- `tx_start` out 1: one-cycle start pulse to the serializer.
- `tx_packet` out 2: packet type to the serializer (0=DATA0, 1=ACK, 2=NAK, 3=STALL). Registered; stable from the START cycle until the scheduler returns to IDLE.
- `hs_grant` out 1: one-cycle pulse; the handshake request has been accepted.
- `data_grant` out 1: one-cycle pulse; the data request has been accepted.
- `tx_done` out 1: one-cycle pulse; the packet finished without a serializer error.
- `timeout_err` out 1: one-cycle pulse; the serializer did not go active in time.
- `size_err` out 1: one-cycle pulse; the data request was rejected for size.
- `xfer_err` out 1: one-cycle pulse; `tx_error` was seen during the packet.
- `busy` out 1: high in every state except IDLE.
- `pkt_count` out 8: count of completed packets (`tx_done` pulses). Wraps 255→0.

## Operation
- Reset: state IDLE. All outputs 0, including `tx_packet` and `pkt_count`. Internal timer 0 and error latch cleared.
- **IDLE**
  - `hs_req`=1: latch `tx_packet`=`hs_type` (0 mapped to 2), select source HS, go to START.
  - Else `data_req`=1 and `buffer_occupancy` ≤ `MAX_PKT`: latch `tx_packet`=0, select source DATA, go to START.
  - Else `data_req`=1 and `buffer_occupancy` > `MAX_PKT`: pulse `size_err` next cycle, load timer, go to GAP. No start is issued.
  - Handshake has strict priority over data, including when both requests rise on the same cycle.
- **START** (exactly 1 cycle)
  - `tx_start`=1.
  - `hs_grant` or `data_grant`=1 according to the selected source.
  - Timer cleared; go to WAIT_ACT.
- **WAIT_ACT**
  - `tx_transfer_active`=1: go to ACTIVE.
  - Else timer = `START_TIMEOUT`-1: pulse `timeout_err`, go to GAP.
  - Otherwise increment the timer.
- **ACTIVE**
  - `tx_error`=1 on any cycle sets the error latch.
  - `tx_transfer_active`=0: go to GAP.
    - Latch clear: pulse `tx_done` and increment `pkt_count`.
    - Latch set: pulse `xfer_err` instead.
- **GAP**
  - Timer counts up from 0.
  - At `IPG_CYCLES`-1: go to IDLE and clear the error latch.
  - Requests arriving during GAP, WAIT_ACT or ACTIVE are not sampled. They are served from IDLE only.
- Arithmetic: 8-bit timer and 8-bit `pkt_count`, unsigned, wrap-around. Size compare is 7-bit unsigned.
- A `tx_error` seen in WAIT_ACT is ignored. Timeout has its own flag.

## Timing
- Request high on cycle N in IDLE → `tx_start`, grant and valid `tx_packet` on N+1. Latency is 1 clock.
- Grant coincides with `tx_start`. The requester must drop its request by N+2 to avoid a second service after the gap.
- `tx_transfer_active` falling on cycle M:
  - `tx_done`/`xfer_err` and the `pkt_count` update occur on M+1.
  - IDLE is re-entered on M+1+`IPG_CYCLES`.
  - The earliest next `tx_start` is on M+2+`IPG_CYCLES`.
- Timeout: with `tx_transfer_active` never rising after `tx_start` on cycle S, `timeout_err` pulses on S+1+`START_TIMEOUT`.
- All pulse outputs are exactly 1 clock wide and registered. No combinational path from inputs to outputs.
- `rst` mid-packet: state returns to IDLE immediately and every output drops to 0 asynchronously. A serializer transfer already in progress is abandoned. Its falling `tx_transfer_active` is not counted.

## Test plan
- Reset → all outputs 0. Then `hs_req`=1 with `hs_type`=1 → next cycle `tx_start`=1, `hs_grant`=1, `tx_packet`=1. Active held 10 cycles then dropped → `tx_done`=1 one cycle later, `pkt_count`=1.
- `hs_req` and `data_req` rise together with occupancy 8 → ACK/NAK/STALL served first (`hs_grant`, `data_grant`=0). After the 16-cycle gap, `data_grant`=1 with `tx_packet`=0.
- `data_req` with occupancy 65 (`MAX_PKT`=64) → `size_err` pulses once, no `tx_start`. Occupancy 64 → normal grant.
- `tx_start` issued, `tx_transfer_active` held 0 → `timeout_err` exactly 17 cycles after `tx_start`, then `busy`=0 after a further 16 cycles. `pkt_count` unchanged.
- `tx_error` pulsed mid-ACTIVE → `xfer_err`=1 and `tx_done`=0 at end of packet. Run 256 clean packets → `pkt_count` wraps to 0.
- Assert `rst` while in ACTIVE → `busy`, `tx_packet`, `pkt_count`=0 immediately. Next request after release is served normally.
